// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and a start/busy/done handshake.
// Ports: clk, reset, start, op, a, b, hi_we, lo_we, wdata -> busy, done, hi, lo.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] add_a, add_b, add_bx, add_s;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0] quo_n, rem_n;

  assign sgn   = ~op[0];
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Shared adder: shift-add for multiply, trial subtract for divide.
  assign rem_sh = {acc_q, quo_q[WIDTH-1]};
  assign add_a  = div_q ? {1'b0, rem_sh} : {2'b00, acc_q};
  assign add_b  = (div_q || quo_q[0]) ? {2'b00, opb_q} : '0;
  assign add_bx = div_q ? ~add_b : add_b;
  assign add_s  = add_a + add_bx + (WIDTH+2)'(div_q);

  assign prod   = {acc_q, quo_q};
  assign prod_n = negq_q ? -prod : prod;
  assign quo_n  = negq_q ? -quo_q : quo_q;
  assign rem_n  = negr_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (op[1] && b == '0) begin
            state_d = S_DONE;
            hi_d    = a;
            lo_d    = '1;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            div_d   = op[1];
            opb_d   = sgn ? abs_b : b;
            quo_d   = sgn ? abs_a : a;
            acc_d   = '0;
            negq_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = sgn & a[WIDTH-1];
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (div_q) begin
          // Borrow out of the trial subtract means restore.
          acc_d = add_s[WIDTH+1] ? rem_sh[WIDTH-1:0]
                                 : add_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~add_s[WIDTH+1]};
        end else begin
          acc_d = add_s[WIDTH:1];
          quo_d = {add_s[0], quo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
        else cnt_d = cnt_q + 1'b1;
      end
      S_FIXUP: begin
        state_d = S_DONE;
        if (div_q) begin
          hi_d = rem_n;
          lo_d = quo_n;
        end else begin
          hi_d = prod_n[2*WIDTH-1:WIDTH];
          lo_d = prod_n[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Drives and samples on the falling edge; counts checks and errors.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchk = 0;
  int nerr = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int exp_cyc,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int inj_cyc,
                        input logic inj_start,
                        input logic inj_we,
                        input logic st_we);
    logic [31:0] hp, lp;
    int cyc, berr, herr;
    berr = 0;
    herr = 0;
    @(negedge clk);
    hp = hi;
    lp = lo;
    start = 1'b1;
    op = o; a = x; b = y;
    lo_we = st_we;
    wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== (cyc < exp_cyc)) berr++;
      if (hi !== hp || lo !== lp) herr++;
      if (cyc == inj_cyc) begin
        start = inj_start;
        lo_we = inj_we;
        op = DIVU; a = 32'd9; b = 32'd3;
        wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0;
      lo_we = 1'b0;
      cyc++;
    end
    chk({tag, "_donecyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busyprof"}, 32'(berr), 32'd0);
    chk({tag, "_hold"}, 32'(herr), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    hi_we = 1'b1;
    wdata = 32'h0000_ABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h0000_ABCD);
    chk("mthi_lo_kept", lo, 32'd0);

    run_op("multu_ff", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           34, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0);
    run_op("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5,
           34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1'b0, 1'b0, 1'b0);
    run_op("mult_min2", MULT, 32'h8000_0000, 32'h8000_0000,
           34, 32'h4000_0000, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7,
           34, 32'd2, 32'd14, 0, 1'b0, 1'b0, 1'b0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2,
           34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           34, 32'h0, 32'h8000_0000, 0, 1'b0, 1'b0, 1'b0);
    run_op("divu_z", DIVU, 32'h0000_1234, 32'd0,
           1, 32'h0000_1234, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);
    run_op("div_z", DIV, 32'hFFFF_FF00, 32'd0,
           1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0);
    run_op("start_ign", MULTU, 32'd6, 32'd7,
           34, 32'd0, 32'd42, 5, 1'b1, 1'b0, 1'b0);
    run_op("mtlo_calc", MULTU, 32'd3, 32'd5,
           34, 32'd0, 32'd15, 5, 1'b0, 1'b1, 1'b0);
    run_op("mtlo_start", DIVU, 32'd9, 32'd3,
           34, 32'd0, 32'd3, 0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1;
    op = MULTU; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    dn = 0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) dn++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(dn), 32'd0);

    run_op("multu_6x7", MULTU, 32'd6, 32'd7,
           34, 32'd0, 32'd42, 0, 1'b0, 1'b0, 1'b0);

    lo_we = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'h1357_9BDF);
    chk("mtlo_hi_kept", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide unit with its own sequencing FSM and HI/LO registers for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles using one shared adder and a start/busy/done handshake. The main controller holds in its execute state until `done`. `hi` and `lo` feed the MFHI/MFLO writeback path, and MTHI/MTLO write them directly.

## Interface
- `WIDTH`, 32, operand and HI/LO width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request from the main controller.
- `op` in 2: `funct[1:0]` of the instruction.
  - `op[1]`: 1 = divide, 0 = multiply.
  - `op[0]`: 1 = unsigned, 0 = signed.
- `a` in WIDTH: rs operand (multiplicand or dividend), sampled with `start`.
- `b` in WIDTH: rt operand (multiplier or divisor), sampled with `start`.
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `hi` out WIDTH: HI register. Holds the product upper half or the remainder.
- `lo` out WIDTH: LO register. Holds the product lower half or the quotient.

## Operation
States:
- IDLE: waiting.
- CALC: iterating, with iteration counter 0..WIDTH-1.
- FIXUP: sign correction and HI/LO write.
- DONE: completion pulse.

Transitions:
- IDLE or DONE, `start`=1, multiply or divide with nonzero `b` → CALC, counter = 0.
- IDLE or DONE, `start`=1, divide with `b`=0 → DONE.
  - HI ← `a`, LO ← all ones.
  - No iteration and no sign fixup, for both DIV and DIVU.
- DONE with no `start` → IDLE.
- CALC with counter = WIDTH-1 → FIXUP; otherwise stay in CALC and increment the counter.
- FIXUP → DONE.

Operand capture at `start`:
- Signed ops register magnitudes |a| and |b| as unsigned WIDTH-bit values. |0x80000000| = 0x80000000.
- Signed ops latch the result signs: `neg_q = a[MSB]^b[MSB]` and `neg_r = a[MSB]`.
- Unsigned ops take the operands as-is, with both sign flags 0.

Arithmetic in CALC:
- Multiply: radix-2 shift-add on a 2·WIDTH product register, one multiplier bit per cycle, LSB first.
- Divide: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.

FIXUP:
- Multiply: if `neg_q`, take the 2·WIDTH two's-complement negation of the product. Then HI ← upper half, LO ← lower half.
- Divide:
  - LO ← quotient, negated if `neg_q`.
  - HI ← remainder, negated if `neg_r`.
  - All arithmetic is modulo 2^WIDTH, so DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.

Handshake and writes:
- `start` while `busy` is ignored. Operands and op are not re-sampled.
- `hi_we`/`lo_we` write `wdata` at the clock edge only in IDLE or DONE, and only when `start`=0.
- Writes are discarded while `busy`, or when they coincide with an accepted `start`.
- HI and LO are otherwise held between operations.

## Timing
- Reset (synchronous, takes effect at the edge): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Any in-progress operation is abandoned, with no `done` and no HI/LO update.
- Cycle numbering: the edge that samples `start` ends cycle 0.
- `busy` is high in cycles 1..WIDTH+1 (CALC plus FIXUP) and low in IDLE and DONE. The main controller may therefore issue a new `start` in the `done` cycle.
- `done` is high exactly in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Divide by zero: `done` in cycle 1, `busy` never asserted.
- New `hi`/`lo` values are visible in the `done` cycle and stay stable until the next completion, MT write, or reset.
- An MT write is visible in the cycle after the write strobe.
- `busy` and `done` are registered, decoded from state only, never from inputs combinationally.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at cycle 34, `busy` high cycles 1..33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Divides:
  - DIVU 100/7 → LO=14, HI=2.
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 → `done` at cycle 1, `busy` never high, HI=0x1234, LO=0xFFFFFFFF.
- Handshake:
  - Start a MULTU 6×7, then pulse `start` with DIVU 9/3 at cycle 5 → ignored; result HI=0, LO=42 at cycle 34.
  - Assert `reset` at cycle 10 of a MULTU → next cycle `busy`=0, HI=LO=0, and no `done` ever follows.
  - A following MULTU 6×7 → LO=42.
- MT writes:
  - `hi_we` with `wdata`=0xABCD in IDLE → HI=0xABCD next cycle.
  - `lo_we` during CALC → LO unchanged.
  - `lo_we` together with an accepted `start` → write discarded, operation proceeds.
